// File: rtl/riscv_dmem_responder_pkg.sv
// Shared configuration for the data-memory responder slice.
// Holds the core data width, the default decoded address width, the
// response FSM state encodings and the out-of-range address decode.
package riscv_dmem_responder_pkg;

  localparam int XLEN              = 32;
  localparam int DMEM_ADDR_BIT_DEF = 12;

  typedef enum logic [1:0] {
    DMEM_RSP_IDLE = 2'd0,
    DMEM_RSP_WAIT = 2'd1,
    DMEM_RSP_RESP = 2'd2
  } dmemRspState_e;

  // Any set bit above the decoded window makes the access an error.
  function automatic logic addrOutOfRange(input logic [XLEN-1:0] addr, input int addrBit);
    return (addr >> addrBit) != '0;
  endfunction

endpackage

// File: rtl/riscv_dmem_responder_if.sv
// Memory-stage load/store bus between the core (master) and the data memory
// (slave).
//   reqValid/reqReady     request handshake
//   reqWrEn               1 = store, 0 = load
//   reqAddr               byte address
//   reqByteSel            write lane enables, bit n -> bits [8n+7:8n]
//   reqWrData             lane-aligned store data
//   rspValid/rspReady     response handshake
//   rspRdData             full read word, 0 for stores and errors
//   rspErr                address outside the decoded window
interface riscv_dmem_responder_if;
  import riscv_dmem_responder_pkg::*;

  logic            reqValid;
  logic            reqReady;
  logic            reqWrEn;
  logic [XLEN-1:0] reqAddr;
  logic [3:0]      reqByteSel;
  logic [XLEN-1:0] reqWrData;
  logic            rspValid;
  logic            rspReady;
  logic [XLEN-1:0] rspRdData;
  logic            rspErr;

  modport master (
    output reqValid, reqWrEn, reqAddr, reqByteSel, reqWrData, rspReady,
    input  reqReady, rspValid, rspRdData, rspErr
  );

  modport slave (
    input  reqValid, reqWrEn, reqAddr, reqByteSel, reqWrData, rspReady,
    output reqReady, rspValid, rspRdData, rspErr
  );

endinterface

// File: rtl/riscv_dmem_array.sv
// Byte-lane-writable word array with a registered synchronous read.
// Ports:
//   clk      clock, rising edge
//   wrEn     commit the enabled lanes of wrData into word idx
//   rdEn     register word idx into rdData
//   idx      word index shared by read and write
//   byteSel  write lane enables
//   wrData   lane-aligned write data
//   rdData   registered read word (held while rdEn is low)
// Contents are not reset.
module riscv_dmem_array
  import riscv_dmem_responder_pkg::*;
#(
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             wrEn,
  input  logic             rdEn,
  input  logic [IDX_W-1:0] idx,
  input  logic [3:0]       byteSel,
  input  logic [XLEN-1:0]  wrData,
  output logic [XLEN-1:0]  rdData
);

  logic [XLEN-1:0] mem [2**IDX_W];

  always_ff @(posedge clk) begin
    if (rdEn) begin
      rdData <= mem[idx];
    end
    for (int b = 0; b < 4; b++) begin
      if (wrEn && byteSel[b]) begin
        mem[idx][8*b +: 8] <= wrData[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/riscv_dmem_responder.sv
// Data-memory responder for the pipelined RV32I core.
// Accepts one request at a time, commits stores at the acceptance edge,
// reads loads at the edge entering RESP and presents the response after
// WAIT_CYCLES wait states, holding it until the requester takes it.
// Ports:
//   i_clk    clock, rising edge
//   i_rstn   asynchronous active-low reset
//   bus      slave side of the load/store bus
module riscv_dmem_responder
  import riscv_dmem_responder_pkg::*;
#(
  parameter int DMEM_ADDR_BIT = DMEM_ADDR_BIT_DEF,
  parameter int WAIT_CYCLES   = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  riscv_dmem_responder_if.slave  bus
);

  localparam int IDX_W = DMEM_ADDR_BIT - 2;
  localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES);

  dmemRspState_e   state, stateNxt;
  logic [CNT_W-1:0] cnt, cntNxt;
  logic            capWrEn, capErr;
  logic [IDX_W-1:0] capIdx;
  logic            accept, reqErr, enterResp;
  logic [IDX_W-1:0] arrIdx;
  logic            arrWrEn;
  logic [XLEN-1:0] arrRdData;

  assign accept    = (state == DMEM_RSP_IDLE) && bus.reqValid;
  assign reqErr    = addrOutOfRange(bus.reqAddr, DMEM_ADDR_BIT);
  assign enterResp = (stateNxt == DMEM_RSP_RESP) && (state != DMEM_RSP_RESP);

  // In IDLE the live request addresses the array (store commit, or the read
  // when there are no wait states); afterwards the captured index does.
  assign arrIdx  = (state == DMEM_RSP_IDLE) ? bus.reqAddr[DMEM_ADDR_BIT-1:2] : capIdx;
  assign arrWrEn = accept && bus.reqWrEn && !reqErr;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state   <= DMEM_RSP_IDLE;
      cnt     <= '0;
      capWrEn <= 1'b0;
      capErr  <= 1'b0;
    end else begin
      state <= stateNxt;
      cnt   <= cntNxt;
      if (accept) begin
        capWrEn <= bus.reqWrEn;
        capErr  <= reqErr;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      capIdx <= bus.reqAddr[DMEM_ADDR_BIT-1:2];
    end
  end

  always_comb begin
    stateNxt      = state;
    cntNxt        = cnt;
    bus.reqReady  = 1'b0;
    bus.rspValid  = 1'b0;
    bus.rspErr    = 1'b0;
    bus.rspRdData = '0;
    case (state)
      DMEM_RSP_IDLE: begin
        bus.reqReady = 1'b1;
        if (bus.reqValid) begin
          if (WAIT_CYCLES > 0) begin
            stateNxt = DMEM_RSP_WAIT;
            cntNxt   = CNT_W'(WAIT_CYCLES - 1);
          end else begin
            stateNxt = DMEM_RSP_RESP;
          end
        end
      end
      DMEM_RSP_WAIT: begin
        if (cnt == '0) begin
          stateNxt = DMEM_RSP_RESP;
        end else begin
          cntNxt = cnt - 1'b1;
        end
      end
      DMEM_RSP_RESP: begin
        bus.rspValid = 1'b1;
        bus.rspErr   = capErr;
        // Stores and rejected accesses always return zero data.
        if (!capWrEn && !capErr) begin
          bus.rspRdData = arrRdData;
        end
        if (bus.rspReady) begin
          stateNxt = DMEM_RSP_IDLE;
        end
      end
      default: stateNxt = DMEM_RSP_IDLE;
    endcase
  end

  riscv_dmem_array #(
    .IDX_W (IDX_W)
  ) uArray (
    .clk     (i_clk),
    .wrEn    (arrWrEn),
    .rdEn    (enterResp),
    .idx     (arrIdx),
    .byteSel (bus.reqByteSel),
    .wrData  (bus.reqWrData),
    .rdData  (arrRdData)
  );

endmodule

// File: tb/tb_riscv_dmem_responder.sv
module tb_riscv_dmem_responder;
  import riscv_dmem_responder_pkg::*;

  localparam int WAIT_A = 2;
  localparam int WAIT_B = 0;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  riscv_dmem_responder_if busA ();
  riscv_dmem_responder_if busB ();

  riscv_dmem_responder #(.DMEM_ADDR_BIT(12), .WAIT_CYCLES(WAIT_A)) dutA (
    .i_clk (clk), .i_rstn (rstn), .bus (busA)
  );
  riscv_dmem_responder #(.DMEM_ADDR_BIT(12), .WAIT_CYCLES(WAIT_B)) dutB (
    .i_clk (clk), .i_rstn (rstn), .bus (busB)
  );

  // Stimulus is routed to one instance at a time.
  logic        useB       = 1'b0;
  logic        reqValid   = 1'b0;
  logic        reqWrEn    = 1'b0;
  logic [31:0] reqAddr    = '0;
  logic [3:0]  reqByteSel = '0;
  logic [31:0] reqWrData  = '0;
  logic        rspReady   = 1'b0;

  assign busA.reqValid   = reqValid & ~useB;
  assign busA.reqWrEn    = reqWrEn;
  assign busA.reqAddr    = reqAddr;
  assign busA.reqByteSel = reqByteSel;
  assign busA.reqWrData  = reqWrData;
  assign busA.rspReady   = rspReady & ~useB;
  assign busB.reqValid   = reqValid & useB;
  assign busB.reqWrEn    = reqWrEn;
  assign busB.reqAddr    = reqAddr;
  assign busB.reqByteSel = reqByteSel;
  assign busB.reqWrData  = reqWrData;
  assign busB.rspReady   = rspReady & useB;

  logic        obsReqReady, obsRspValid, obsRspErr;
  logic [31:0] obsRspRdData;
  assign obsReqReady  = useB ? busB.reqReady  : busA.reqReady;
  assign obsRspValid  = useB ? busB.rspValid  : busA.rspValid;
  assign obsRspErr    = useB ? busB.rspErr    : busA.rspErr;
  assign obsRspRdData = useB ? busB.rspRdData : busA.rspRdData;

  // Reference memory contents, one image per instance.
  logic [31:0] refMem [2][1024];

  int nChecks = 0;
  int nFails  = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Applies a store to the reference image if the address is in range.
  task automatic modelAccept(input logic wr, input logic [31:0] addr, input logic [3:0] sel,
                             input logic [31:0] wdata);
    int inst;
    int idx;
    inst = useB ? 1 : 0;
    idx  = int'(addr[11:2]);
    if (wr && (addr < 32'h1000)) begin
      for (int b = 0; b < 4; b++) begin
        if (sel[b]) refMem[inst][idx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
  endtask

  task automatic doTxn(input logic wr, input logic [31:0] addr, input logic [3:0] sel,
                       input logic [31:0] wdata, input int hold);
    int          lat;
    int          latExp;
    int          inst;
    logic        expErr;
    logic [31:0] expData;
    logic [31:0] held;
    inst   = useB ? 1 : 0;
    latExp = (useB ? WAIT_B : WAIT_A) + 1;
    @(negedge clk);
    reqValid = 1'b1; reqWrEn = wr; reqAddr = addr; reqByteSel = sel; reqWrData = wdata;
    rspReady = 1'b0;
    checkVal("reqReady idle", obsReqReady, 1);
    @(posedge clk);
    modelAccept(wr, addr, sel, wdata);
    expErr  = (addr >= 32'h1000);
    expData = (wr || expErr) ? 32'h0 : refMem[inst][int'(addr[11:2])];
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        // Garbage on the request side must be ignored until IDLE again.
        reqWrEn = 1'($urandom); reqAddr = $urandom; reqByteSel = 4'($urandom);
        reqWrData = $urandom;
      end
      if (!obsRspValid) checkVal("reqReady wait", obsReqReady, 0);
    end while (!obsRspValid && lat < 20);
    checkVal("latency", lat, latExp);
    if (!obsRspValid) begin
      reqValid = 1'b0;
      return;
    end
    checkVal("rspErr", obsRspErr, expErr);
    checkVal("rspRdData", obsRspRdData, expData);
    checkVal("reqReady resp", obsReqReady, 0);
    held = obsRspRdData;
    repeat (hold) begin
      @(negedge clk);
      checkVal("hold valid", obsRspValid, 1);
      checkVal("hold data", obsRspRdData, held);
      checkVal("hold reqReady", obsReqReady, 0);
    end
    rspReady = 1'b1;
    @(negedge clk);
    rspReady = 1'b0;
    reqValid = 1'b0;
    checkVal("released valid", obsRspValid, 0);
    checkVal("released reqReady", obsReqReady, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    repeat (3) @(negedge clk);
    checkVal("reset reqReady A", busA.reqReady, 1);
    checkVal("reset rspValid A", busA.rspValid, 0);
    checkVal("reset rspRdData A", busA.rspRdData, 0);
    checkVal("reset rspErr A", busA.rspErr, 0);
    checkVal("reset reqReady B", busB.reqReady, 1);
    checkVal("reset rspValid B", busB.rspValid, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Instance A: initialise words 0..63.
    useB = 1'b0;
    for (int w = 0; w < 64; w++) doTxn(1'b1, 32'(w * 4), 4'hF, $urandom, 0);

    doTxn(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 0);
    doTxn(1'b0, 32'h10, 4'h0, 32'h0, 0);
    checkVal("directed load 0x10", refMem[0][4], 32'hDEADBEEF);
    doTxn(1'b1, 32'h10, 4'b0010, 32'h0000AA00, 0);
    doTxn(1'b0, 32'h13, 4'hF, 32'h0, 5);
    doTxn(1'b1, 32'h20, 4'hF, 32'h12345678, 0);
    doTxn(1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, 0);
    doTxn(1'b0, 32'h20, 4'h0, 32'h0, 1);
    doTxn(1'b1, 32'h1000, 4'hF, 32'h55AA55AA, 0);
    doTxn(1'b0, 32'h0, 4'h0, 32'h0, 0);
    doTxn(1'b0, 32'h80000004, 4'h0, 32'h0, 2);

    // Reset during WAIT: store stays committed, outputs clear at once.
    @(negedge clk);
    reqValid = 1'b1; reqWrEn = 1'b1; reqAddr = 32'h40; reqByteSel = 4'hF;
    reqWrData = 32'h11223344;
    @(posedge clk);
    modelAccept(1'b1, 32'h40, 4'hF, 32'h11223344);
    @(negedge clk);
    reqValid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    checkVal("async rst reqReady", obsReqReady, 1);
    checkVal("async rst rspValid", obsRspValid, 0);
    checkVal("async rst rspRdData", obsRspRdData, 0);
    @(negedge clk);
    rstn = 1'b1;
    doTxn(1'b0, 32'h40, 4'h0, 32'h0, 0);

    // Randomised mix on instance A.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) a = 32'h1000 | $urandom;
      else a = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
      doTxn(1'($urandom), a, 4'($urandom), $urandom, $urandom_range(0, 3));
    end

    // Instance B: no wait states.
    useB = 1'b1;
    for (int w = 0; w < 4; w++) doTxn(1'b1, 32'(w * 4), 4'hF, $urandom, 0);
    doTxn(1'b1, 32'h0, 4'hF, 32'hCAFEF00D, 0);
    doTxn(1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, 1);
    doTxn(1'b0, 32'h0, 4'h0, 32'h0, 0);
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 5) == 0) a = 32'h1000 | $urandom;
      else a = 32'($urandom_range(0, 3) * 4 + $urandom_range(0, 3));
      doTxn(1'($urandom), a, 4'($urandom), $urandom, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
